// File: rtl/axis_noc_pkg.sv
// Shared NoC egress types: default flit payload layout and width helpers.
package axis_noc_pkg;

    localparam int unsigned DEF_TDATA_WIDTH = 512;
    localparam int unsigned DEF_SF          = 4;
    localparam int unsigned DEF_TID_WIDTH   = 2;
    localparam int unsigned DEF_TDEST_WIDTH = 4;
    localparam int unsigned DEF_FLIT_WIDTH  = DEF_TDATA_WIDTH / DEF_SF;
    localparam int unsigned DEF_DEST_WIDTH  = DEF_TID_WIDTH + DEF_TDEST_WIDTH;

    function automatic int unsigned flit_width(input int unsigned tdata_w, input int unsigned sf);
        return tdata_w / sf;
    endfunction

    function automatic int unsigned dest_width(input int unsigned tid_w, input int unsigned tdest_w);
        return tid_w + tdest_w;
    endfunction

    typedef struct packed {
        logic [DEF_FLIT_WIDTH-1:0] data;
        logic [DEF_DEST_WIDTH-1:0] dest;
        logic                      is_tail;
    } flit_t;

endpackage

// File: rtl/noc_flit_fifo.sv
// Flit buffer; a pop frees its slot in the same cycle, so push is accepted when full if popping.
module noc_flit_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter type         flit_t = axis_noc_pkg::flit_t
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  flit_t wdata,
    input  logic  pop,
    output flit_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    flit_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/axis_flit_deserializer.sv
// NoC egress endpoint: buffers credited flits and reassembles SERIALIZATION_FACTOR of them per AXIS beat.
module axis_flit_deserializer
    import axis_noc_pkg::*;
#(
    parameter int unsigned TDEST_WIDTH          = 4,
    parameter int unsigned TID_WIDTH            = 2,
    parameter int unsigned TDATA_WIDTH          = 512,
    parameter int unsigned SERIALIZATION_FACTOR = 4,
    parameter int unsigned FLIT_BUFFER_DEPTH    = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0] data_in,
    input  logic [TID_WIDTH+TDEST_WIDTH-1:0]      dest_in,
    input  logic                                  is_tail_in,
    input  logic                                  send_in,
    output logic                                  credit_out,
    output logic                                  axis_tvalid,
    input  logic                                  axis_tready,
    output logic [TDATA_WIDTH-1:0]                axis_tdata,
    output logic                                  axis_tlast,
    output logic [TID_WIDTH-1:0]                  axis_tid,
    output logic [TDEST_WIDTH-1:0]                axis_tdest,
    output logic                                  overflow_err
);

    localparam int unsigned SF     = SERIALIZATION_FACTOR;
    localparam int unsigned FLIT_W = flit_width(TDATA_WIDTH, SF);
    localparam int unsigned DEST_W = dest_width(TID_WIDTH, TDEST_WIDTH);
    localparam int unsigned CNT_W  = (SF > 1) ? $clog2(SF) : 1;

    typedef struct packed {
        logic [FLIT_W-1:0] data;
        logic [DEST_W-1:0] dest;
        logic              is_tail;
    } flit_s;

    flit_s             wr_flit;
    flit_s             head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              load;
    logic              closes_beat_c;
    logic [CNT_W-1:0]  cnt;
    logic [FLIT_W-1:0] partial [SF];
    logic [DEST_W-1:0] dest_q;
    logic [TDATA_WIDTH-1:0] beat_c;
    logic [DEST_W-1:0] beat_dest_c;

    assign wr_flit = '{data: data_in, dest: dest_in, is_tail: is_tail_in};

    noc_flit_fifo #(
        .DEPTH  (FLIT_BUFFER_DEPTH),
        .flit_t (flit_s)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (send_in),
        .wdata (wr_flit),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A flit that closes a beat (last slot or early tail) may only pop when the output register is free.
    assign closes_beat_c = (cnt == CNT_W'(SF - 1)) || head.is_tail;
    assign pop           = !fifo_empty && (!closes_beat_c || !axis_tvalid || axis_tready);
    assign load          = pop && closes_beat_c;

    // Slots below cnt come from partial, slot cnt is the head flit, higher slots stay zero.
    always_comb begin
        beat_c = '0;
        for (int k = 0; k < SF; k++) begin
            if (CNT_W'(k) < cnt) begin
                beat_c[k*FLIT_W +: FLIT_W] = partial[k];
            end else if (CNT_W'(k) == cnt) begin
                beat_c[k*FLIT_W +: FLIT_W] = head.data;
            end
        end
        beat_dest_c = (cnt == '0) ? head.dest : dest_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            dest_q       <= '0;
            for (int k = 0; k < SF; k++) partial[k] <= '0;
            axis_tvalid  <= 1'b0;
            axis_tdata   <= '0;
            axis_tlast   <= 1'b0;
            axis_tid     <= '0;
            axis_tdest   <= '0;
            credit_out   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            credit_out <= pop;
            if (send_in && fifo_full && !pop) overflow_err <= 1'b1;
            if (pop && (cnt == '0)) dest_q <= head.dest;
            if (load) begin
                cnt                    <= '0;
                axis_tdata             <= beat_c;
                axis_tlast             <= head.is_tail;
                {axis_tid, axis_tdest} <= beat_dest_c;
                axis_tvalid            <= 1'b1;
            end else begin
                if (pop) begin
                    partial[cnt] <= head.data;
                    cnt          <= cnt + CNT_W'(1);
                end
                if (axis_tready) axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_flit_deserializer.sv
// Directed bench for axis_flit_deserializer: vector table plus multi-cycle corner-case sequences.
module tb_axis_flit_deserializer;

    logic         clk;
    logic         rst_n;
    logic [127:0] data_in;
    logic [5:0]   dest_in;
    logic         is_tail_in;
    logic         send_in;
    logic         credit_out;
    logic         axis_tvalid;
    logic         axis_tready;
    logic [511:0] axis_tdata;
    logic         axis_tlast;
    logic [1:0]   axis_tid;
    logic [3:0]   axis_tdest;
    logic         overflow_err;

    axis_flit_deserializer #(
        .TDEST_WIDTH          (4),
        .TID_WIDTH            (2),
        .TDATA_WIDTH          (512),
        .SERIALIZATION_FACTOR (4),
        .FLIT_BUFFER_DEPTH    (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .dest_in      (dest_in),
        .is_tail_in   (is_tail_in),
        .send_in      (send_in),
        .credit_out   (credit_out),
        .axis_tvalid  (axis_tvalid),
        .axis_tready  (axis_tready),
        .axis_tdata   (axis_tdata),
        .axis_tlast   (axis_tlast),
        .axis_tid     (axis_tid),
        .axis_tdest   (axis_tdest),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         send;
        logic [127:0] data;
        logic [5:0]   dest;
        logic         tail;
        logic         tready;
        logic         e_valid;
        logic         e_credit;
        logic         e_last;
        logic [511:0] e_data;
        logic [5:0]   e_dest;
    } vec_t;

    typedef struct {
        logic [511:0] data;
        logic         last;
        logic [5:0]   dest;
        int           cyc;
    } beat_t;

    vec_t  vecs[$];
    beat_t beats[$];
    int    checks = 0;
    int    errors = 0;
    int    cred = 4;
    int    cred_total = 0;
    int    cyc = 0;
    int    used;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] b4(input logic [127:0] a3, input logic [127:0] a2,
                                        input logic [127:0] a1, input logic [127:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    // One clock: log a handshake about to happen, then count the returned credit.
    task automatic tick();
        beat_t b;
        if (axis_tvalid && axis_tready) begin
            b.data = axis_tdata;
            b.last = axis_tlast;
            b.dest = {axis_tid, axis_tdest};
            b.cyc  = cyc;
            beats.push_back(b);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (credit_out) begin
            cred++;
            cred_total++;
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        send_in     = 1'b0;
        data_in     = '0;
        dest_in     = '0;
        is_tail_in  = 1'b0;
        axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        cred       = 4;
        cred_total = 0;
        beats.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_flits(input int n, input logic [127:0] base, input logic [5:0] dest,
                              input logic [15:0] tails, output int cycles);
        int sent;
        sent   = 0;
        cycles = 0;
        while (sent < n && cycles < 200) begin
            if (cred > 0) begin
                send_in    = 1'b1;
                data_in    = base + 128'(sent);
                dest_in    = dest;
                is_tail_in = tails[sent];
                cred--;
                sent++;
            end else begin
                send_in = 1'b0;
            end
            tick();
            cycles++;
        end
        send_in    = 1'b0;
        is_tail_in = 1'b0;
        chk("send_budget", 512'(sent), 512'(n));
    endtask

    task automatic add_vec(input logic send, input logic [127:0] data, input logic [5:0] dest,
                           input logic tail, input logic ev, input logic ec, input logic el,
                           input logic [511:0] ed, input logic [5:0] edst);
        vec_t v;
        v.send = send; v.data = data; v.dest = dest; v.tail = tail; v.tready = 1'b1;
        v.e_valid = ev; v.e_credit = ec; v.e_last = el; v.e_data = ed; v.e_dest = edst;
        vecs.push_back(v);
    endtask

    task automatic chk_beat(input int idx, input logic [511:0] d, input logic [5:0] dst, input logic l);
        chk($sformatf("beat%0d_data", idx), beats[idx].data, d);
        chk($sformatf("beat%0d_dest", idx), 512'(beats[idx].dest), 512'(dst));
        chk($sformatf("beat%0d_last", idx), 512'(beats[idx].last), 512'(l));
    endtask

    initial begin
        // Full beat with tail on flit 3, then early tail on flit 1 and a single-flit tail packet.
        add_vec(1, 128'h1, 6'h19, 0, 0, 0, 0, '0, 6'h0);
        add_vec(1, 128'h2, 6'h19, 0, 0, 1, 0, '0, 6'h0);
        add_vec(1, 128'h3, 6'h19, 0, 0, 1, 0, '0, 6'h0);
        add_vec(1, 128'h4, 6'h19, 1, 0, 1, 0, '0, 6'h0);
        add_vec(0, 128'h0, 6'h00, 0, 1, 1, 1, b4(128'h4, 128'h3, 128'h2, 128'h1), 6'h19);
        add_vec(0, 128'h0, 6'h00, 0, 0, 0, 0, '0, 6'h0);
        add_vec(1, 128'hA0, 6'h2A, 0, 0, 0, 0, '0, 6'h0);
        add_vec(1, 128'hA1, 6'h2A, 1, 0, 1, 0, '0, 6'h0);
        add_vec(1, 128'hB0, 6'h35, 1, 1, 1, 1, b4(128'h0, 128'h0, 128'hA1, 128'hA0), 6'h2A);
        add_vec(0, 128'h0, 6'h00, 0, 1, 1, 1, b4(128'h0, 128'h0, 128'h0, 128'hB0), 6'h35);
        add_vec(0, 128'h0, 6'h00, 0, 0, 0, 0, '0, 6'h0);

        do_reset();
        chk("rst_tvalid", 512'(axis_tvalid), 512'(0));
        chk("rst_tdata", axis_tdata, '0);
        chk("rst_tlast", 512'(axis_tlast), 512'(0));
        chk("rst_tid_tdest", 512'({axis_tid, axis_tdest}), 512'(0));
        chk("rst_credit", 512'(credit_out), 512'(0));
        chk("rst_overflow", 512'(overflow_err), 512'(0));

        foreach (vecs[i]) begin
            send_in     = vecs[i].send;
            data_in     = vecs[i].data;
            dest_in     = vecs[i].dest;
            is_tail_in  = vecs[i].tail;
            axis_tready = vecs[i].tready;
            tick();
            chk($sformatf("vec%0d_tvalid", i), 512'(axis_tvalid), 512'(vecs[i].e_valid));
            chk($sformatf("vec%0d_credit", i), 512'(credit_out), 512'(vecs[i].e_credit));
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d_tdata", i), axis_tdata, vecs[i].e_data);
                chk($sformatf("vec%0d_tlast", i), 512'(axis_tlast), 512'(vecs[i].e_last));
                chk($sformatf("vec%0d_dest", i), 512'({axis_tid, axis_tdest}), 512'(vecs[i].e_dest));
            end
        end
        send_in = 1'b0;
        chk("vec_credits", 512'(cred_total), 512'(7));

        // Backpressure: 8 credited flits while the sink is stalled, then release.
        do_reset();
        send_flits(8, 128'h10, 6'h07, 16'h0088, used);
        idle(2);
        chk("bp_tvalid_held", 512'(axis_tvalid), 512'(1));
        chk("bp_no_beats", 512'(beats.size()), 512'(0));
        chk("bp_cred_held", 512'(cred), 512'(3));
        axis_tready = 1'b1;
        idle(10);
        chk("bp_beats", 512'(beats.size()), 512'(2));
        if (beats.size() == 2) begin
            chk_beat(0, b4(128'h13, 128'h12, 128'h11, 128'h10), 6'h07, 1'b1);
            chk_beat(1, b4(128'h17, 128'h16, 128'h15, 128'h14), 6'h07, 1'b1);
        end
        chk("bp_credit_total", 512'(cred_total), 512'(8));
        chk("bp_overflow", 512'(overflow_err), 512'(0));

        // Overflow: fill everything, push one uncredited flit, confirm drop and stickiness.
        do_reset();
        send_flits(11, 128'h20, 6'h3F, 16'h0000, used);
        idle(2);
        chk("ovf_cred_zero", 512'(cred), 512'(0));
        chk("ovf_pre", 512'(overflow_err), 512'(0));
        send_in = 1'b1;
        data_in = 128'h99;
        dest_in = 6'h3F;
        tick();
        send_in = 1'b0;
        chk("ovf_set", 512'(overflow_err), 512'(1));
        axis_tready = 1'b1;
        idle(10);
        send_flits(1, 128'h2B, 6'h3F, 16'h0001, used);
        idle(5);
        chk("ovf_beats", 512'(beats.size()), 512'(3));
        if (beats.size() == 3) begin
            chk_beat(1, b4(128'h27, 128'h26, 128'h25, 128'h24), 6'h3F, 1'b0);
            chk_beat(2, b4(128'h2B, 128'h2A, 128'h29, 128'h28), 6'h3F, 1'b1);
        end
        chk("ovf_sticky", 512'(overflow_err), 512'(1));
        do_reset();
        chk("ovf_cleared", 512'(overflow_err), 512'(0));

        // Streaming: one flit per cycle gives one beat every 4 cycles.
        axis_tready = 1'b1;
        send_flits(8, 128'h40, 6'h0C, 16'h0080, used);
        chk("stream_cycles", 512'(used), 512'(8));
        chk("stream_credit_hi", 512'(credit_out), 512'(1));
        idle(4);
        chk("stream_beats", 512'(beats.size()), 512'(2));
        if (beats.size() == 2) begin
            chk("stream_spacing", 512'(beats[1].cyc - beats[0].cyc), 512'(4));
            chk_beat(1, b4(128'h47, 128'h46, 128'h45, 128'h44), 6'h0C, 1'b1);
        end
        chk("stream_credit_total", 512'(cred_total), 512'(8));

        // Asynchronous reset mid-beat with a held output and two partial flits.
        do_reset();
        send_flits(6, 128'h50, 6'h11, 16'h0000, used);
        idle(1);
        chk("ar_pre_tvalid", 512'(axis_tvalid), 512'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("ar_tvalid", 512'(axis_tvalid), 512'(0));
        chk("ar_tdata", axis_tdata, '0);
        chk("ar_tlast_id", 512'({axis_tlast, axis_tid, axis_tdest}), 512'(0));
        chk("ar_credit", 512'(credit_out), 512'(0));
        do_reset();
        axis_tready = 1'b1;
        send_flits(4, 128'h61, 6'h22, 16'h0008, used);
        idle(4);
        chk("ar_post_beats", 512'(beats.size()), 512'(1));
        if (beats.size() == 1) begin
            chk_beat(0, b4(128'h64, 128'h63, 128'h62, 128'h61), 6'h22, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
